// File: rtl/reg_file_wb.sv
// Write-back stage register file: formats load data, selects the commit value,
// writes a 32x32 array with x0 hard-wired to zero and serves two bypassed read ports.
module reg_file_wb #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we_regW,
    input  logic                    mux9W,
    input  logic                    mux5,
    input  logic [XLEN-1:0]         resultW,
    input  logic [XLEN-1:0]         memW,
    input  logic [XLEN-1:0]         pc,
    input  logic [$clog2(NREG)-1:0] rdW,
    input  logic [1:0]              ld_size,
    input  logic                    ld_uns,
    input  logic [1:0]              ld_off,
    input  logic [$clog2(NREG)-1:0] ra1,
    input  logic [$clog2(NREG)-1:0] ra2,
    output logic [XLEN-1:0]         rd1,
    output logic [XLEN-1:0]         rd2,
    output logic [XLEN-1:0]         wb_data,
    output logic                    wb_valid,
    output logic [31:0]             wb_count
);

    logic [XLEN-1:0] regs [NREG];
    logic [7:0]      ldByte;
    logic [15:0]     ldHalf;
    logic [XLEN-1:0] ldData;
    logic [31:0]     wbCount;

    always_comb begin
        ldByte = memW[7:0];
        case (ld_off)
            2'd0: ldByte = memW[7:0];
            2'd1: ldByte = memW[15:8];
            2'd2: ldByte = memW[23:16];
            2'd3: ldByte = memW[31:24];
            default: ldByte = memW[7:0];
        endcase
        ldHalf = ld_off[1] ? memW[31:16] : memW[15:0];
    end

    always_comb begin
        ldData = memW;
        case (ld_size)
            2'b00:   ldData = {{(XLEN-8){~ld_uns & ldByte[7]}}, ldByte};
            2'b01:   ldData = {{(XLEN-16){~ld_uns & ldHalf[15]}}, ldHalf};
            default: ldData = memW;
        endcase
    end

    always_comb begin
        wb_data = resultW;
        if (mux5) begin
            wb_data = pc;
        end else if (mux9W) begin
            wb_data = ldData;
        end
    end

    assign wb_valid = we_regW && (rdW != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs    <= '{default: '0};
            wbCount <= '0;
        end else if (wb_valid) begin
            regs[rdW] <= wb_data;
            wbCount   <= wbCount + 32'd1;
        end
    end

    assign wb_count = wbCount;

    // Bypass is suppressed while reset is held so reads stay zero during reset.
    always_comb begin
        rd1 = regs[ra1];
        rd2 = regs[ra2];
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (rst_n && wb_valid && (ra1 == rdW)) begin
            rd1 = wb_data;
        end
        if (ra2 == '0) begin
            rd2 = '0;
        end else if (rst_n && wb_valid && (ra2 == rdW)) begin
            rd2 = wb_data;
        end
    end

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed self-checking bench for reg_file_wb: reset, bypass, x0, load
// formatting, select priority, held/back-to-back writes and asynchronous reset.
module tb_reg_file_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we_regW;
    logic        mux9W;
    logic        mux5;
    logic [31:0] resultW;
    logic [31:0] memW;
    logic [31:0] pc;
    logic [4:0]  rdW;
    logic [1:0]  ld_size;
    logic        ld_uns;
    logic [1:0]  ld_off;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] wb_data;
    logic        wb_valid;
    logic [31:0] wb_count;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] expCount = '0;

    reg_file_wb #(.XLEN(32), .NREG(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_regW  (we_regW),
        .mux9W    (mux9W),
        .mux5     (mux5),
        .resultW  (resultW),
        .memW     (memW),
        .pc       (pc),
        .rdW      (rdW),
        .ld_size  (ld_size),
        .ld_uns   (ld_uns),
        .ld_off   (ld_off),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .wb_data  (wb_data),
        .wb_valid (wb_valid),
        .wb_count (wb_count)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n   = 1'b0;
        we_regW = 1'b0;
        mux9W   = 1'b0;
        mux5    = 1'b0;
        resultW = '0;
        memW    = '0;
        pc      = '0;
        rdW     = '0;
        ld_size = 2'b10;
        ld_uns  = 1'b0;
        ld_off  = '0;
        ra1     = '0;
        ra2     = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            #1;
            total++;
            if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
                bad++;
                $display("FAIL reset_read addr=%0d rd1=%h rd2=%h required 0", i, rd1, rd2);
            end
        end
        total++;
        if (wb_count !== 32'h0) begin
            bad++;
            $display("FAIL reset_count got=%h required 0", wb_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_write();
        @(negedge clk);
        we_regW = 1'b1; rdW = 5'd5; resultW = 32'hDEADBEEF; mux9W = 1'b0; mux5 = 1'b0;
        ra1 = 5'd5;
        #1;
        total++;
        if (rd1 !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL bypass_x5 got=%h required=%h", rd1, 32'hDEADBEEF);
        end
        total++;
        if (wb_valid !== 1'b1 || wb_data !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL wb_out_x5 valid=%b data=%h required 1/%h", wb_valid, wb_data, 32'hDEADBEEF);
        end
        @(posedge clk);
        expCount++;
        #1 we_regW = 1'b0;
        #1;
        total++;
        if (rd1 !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL array_x5 got=%h required=%h", rd1, 32'hDEADBEEF);
        end
        total++;
        if (wb_count !== expCount) begin
            bad++;
            $display("FAIL count_x5 got=%0d required=%0d", wb_count, expCount);
        end
    endtask

    task automatic test_x0();
        @(negedge clk);
        we_regW = 1'b1; rdW = 5'd0; resultW = 32'h12345678; ra1 = 5'd0;
        #1;
        total++;
        if (rd1 !== 32'h0 || wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL x0_bypass rd1=%h valid=%b required 0/0", rd1, wb_valid);
        end
        @(posedge clk);
        #1 we_regW = 1'b0;
        #1;
        total++;
        if (rd1 !== 32'h0) begin
            bad++;
            $display("FAIL x0_array got=%h required 0", rd1);
        end
        total++;
        if (wb_count !== expCount) begin
            bad++;
            $display("FAIL x0_count got=%0d required=%0d", wb_count, expCount);
        end
    endtask

    task automatic test_load_format();
        logic [1:0]  sz  [8];
        logic [1:0]  off [8];
        logic        uns [8];
        logic [31:0] exp [8];
        sz = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 2'b01, 2'b11};
        off = '{2'd2, 2'd3, 2'd0, 2'd2, 2'd1, 2'd1, 2'd3, 2'd3};
        uns = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp = '{32'hFFFFFFFF, 32'h00000080, 32'h00007F01, 32'hFFFF80FF,
                32'h80FF7F01, 32'h0000007F, 32'h000080FF, 32'h80FF7F01};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            we_regW = 1'b1; rdW = 5'd3; mux9W = 1'b1; mux5 = 1'b0;
            memW = 32'h80FF7F01; resultW = 32'h0BAD0BAD;
            ld_size = sz[i]; ld_off = off[i]; ld_uns = uns[i];
            ra2 = 5'd3;
            #1;
            total++;
            if (wb_data !== exp[i]) begin
                bad++;
                $display("FAIL load_fmt case=%0d wb_data=%h required=%h", i, wb_data, exp[i]);
            end
            @(posedge clk);
            expCount++;
            #1 we_regW = 1'b0;
            #1;
            total++;
            if (rd2 !== exp[i]) begin
                bad++;
                $display("FAIL load_commit case=%0d rd2=%h required=%h", i, rd2, exp[i]);
            end
        end
        mux9W = 1'b0;
        total++;
        if (wb_count !== expCount) begin
            bad++;
            $display("FAIL load_count got=%0d required=%0d", wb_count, expCount);
        end
    endtask

    task automatic test_select();
        @(negedge clk);
        we_regW = 1'b1; rdW = 5'd1; mux5 = 1'b1; mux9W = 1'b1;
        pc = 32'h00000104; resultW = 32'hAAAA0000; memW = 32'h80FF7F01; ld_size = 2'b10;
        @(posedge clk);
        expCount++;
        #1 we_regW = 1'b0; ra1 = 5'd1;
        #1;
        total++;
        if (rd1 !== 32'h00000104) begin
            bad++;
            $display("FAIL sel_pc got=%h required=%h", rd1, 32'h00000104);
        end
        @(negedge clk);
        we_regW = 1'b1; mux5 = 1'b0; mux9W = 1'b0;
        @(posedge clk);
        expCount++;
        #1 we_regW = 1'b0;
        #1;
        total++;
        if (rd1 !== 32'hAAAA0000) begin
            bad++;
            $display("FAIL sel_alu got=%h required=%h", rd1, 32'hAAAA0000);
        end
    endtask

    task automatic test_back_to_back();
        // Held bundle: same write on three edges, counted each time.
        @(negedge clk);
        we_regW = 1'b1; rdW = 5'd12; resultW = 32'h00000011; mux5 = 1'b0; mux9W = 1'b0;
        ra1 = 5'd12; ra2 = 5'd12;
        #1;
        total++;
        if (rd1 !== 32'h00000011 || rd2 !== 32'h00000011) begin
            bad++;
            $display("FAIL dual_bypass rd1=%h rd2=%h required=%h", rd1, rd2, 32'h00000011);
        end
        repeat (3) @(posedge clk);
        expCount += 3;
        #1;
        total++;
        if (wb_count !== expCount) begin
            bad++;
            $display("FAIL held_count got=%0d required=%0d", wb_count, expCount);
        end
        @(negedge clk);
        rdW = 5'd13; resultW = 32'hCAFE0013;
        @(negedge clk);
        rdW = 5'd14; resultW = 32'hCAFE0014; ra1 = 5'd13; ra2 = 5'd14;
        #1;
        total++;
        if (rd1 !== 32'hCAFE0013 || rd2 !== 32'hCAFE0014) begin
            bad++;
            $display("FAIL b2b rd1=%h rd2=%h required %h/%h", rd1, rd2, 32'hCAFE0013, 32'hCAFE0014);
        end
        @(posedge clk);
        expCount += 2;
        #1 we_regW = 1'b0; ra1 = 5'd12;
        #1;
        total++;
        if (rd1 !== 32'h00000011 || rd2 !== 32'hCAFE0014 || wb_count !== expCount) begin
            bad++;
            $display("FAIL b2b_array rd1=%h rd2=%h cnt=%0d required %h/%h/%0d",
                     rd1, rd2, wb_count, 32'h00000011, 32'hCAFE0014, expCount);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        we_regW = 1'b1; rdW = 5'd9; resultW = 32'h00000055; ra1 = 5'd9;
        @(posedge clk);
        expCount++;
        #1 we_regW = 1'b0;
        #1;
        total++;
        if (rd1 !== 32'h00000055) begin
            bad++;
            $display("FAIL pre_reset_x9 got=%h required=%h", rd1, 32'h00000055);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (rd1 !== 32'h0 || wb_count !== 32'h0) begin
            bad++;
            $display("FAIL async_clear rd1=%h cnt=%0d required 0/0", rd1, wb_count);
        end
        we_regW = 1'b1; resultW = 32'h00000077;
        #1;
        total++;
        if (rd1 !== 32'h0) begin
            bad++;
            $display("FAIL reset_bypass got=%h required 0", rd1);
        end
        @(negedge clk);
        we_regW = 1'b0;
        rst_n = 1'b1;
        #1;
        total++;
        if (rd1 !== 32'h0 || wb_count !== 32'h0) begin
            bad++;
            $display("FAIL reset_write_lost rd1=%h cnt=%0d required 0/0", rd1, wb_count);
        end
        ra1 = 5'd5;
        #1;
        total++;
        if (rd1 !== 32'h0) begin
            bad++;
            $display("FAIL reset_x5_cleared got=%h required 0", rd1);
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_x0();
        test_load_format();
        test_select();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
